// File: rtl/laundry_vend_ctrl_pkg.sv
// Shared constants for the laundry vend controller:
// coin values, FSM states, default prices, digit patterns.
package laundry_vend_ctrl_pkg;

   localparam logic [7:0] NICKEL_N  = 8'd1;
   localparam logic [7:0] DIME_N    = 8'd2;
   localparam logic [7:0] QUARTER_N = 8'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_VEND,
      ST_CHANGE
   } state_t;

   localparam int DEF_NUM_PROD = 3;
   localparam logic [47:0] DEF_PRICES =
      {16'd80, 16'd50, 16'd20};

   // Segment order {a,b,c,d,e,f,g}, active-high.
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/laundry_vend_ctrl_if.sv
// Panel-side bundle of the vend controller: coin/select
// inputs, vend/change pulses and the credit display.
interface laundry_vend_ctrl_if #(
   parameter int NUM_PROD = 3
);
   logic                i_nickel;
   logic                i_dime;
   logic                i_quarter;
   logic [NUM_PROD-1:0] i_sel;
   logic                i_cancel;
   logic [NUM_PROD-1:0] o_vend;
   logic                o_deny;
   logic                o_coin_reject;
   logic                o_change_nickel;
   logic                o_busy;
   logic [3:0]          o_bcd_h;
   logic [3:0]          o_bcd_t;
   logic [3:0]          o_bcd_o;
   logic [6:0]          o_seg_h;
   logic [6:0]          o_seg_t;
   logic [6:0]          o_seg_o;
   logic [NUM_PROD-1:0] o_credit_led;

   modport master (
      output i_nickel, i_dime, i_quarter,
      output i_sel, i_cancel,
      input  o_vend, o_deny, o_coin_reject,
      input  o_change_nickel, o_busy,
      input  o_bcd_h, o_bcd_t, o_bcd_o,
      input  o_seg_h, o_seg_t, o_seg_o,
      input  o_credit_led
   );

   modport slave (
      input  i_nickel, i_dime, i_quarter,
      input  i_sel, i_cancel,
      output o_vend, o_deny, o_coin_reject,
      output o_change_nickel, o_busy,
      output o_bcd_h, o_bcd_t, o_bcd_o,
      output o_seg_h, o_seg_t, o_seg_o,
      output o_credit_led
   );
endinterface

// File: rtl/laundry_vend_ctrl_seg7_decode.sv
// One BCD digit to seven-segment pattern.
// Non-decimal codes blank the digit.
module seg7_decode
   import laundry_vend_ctrl_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Digit lookup
   always_comb begin
      o_seg = SEG_OFF;
      case (i_bcd)
         4'd0: o_seg = SEG_0;
         4'd1: o_seg = SEG_1;
         4'd2: o_seg = SEG_2;
         4'd3: o_seg = SEG_3;
         4'd4: o_seg = SEG_4;
         4'd5: o_seg = SEG_5;
         4'd6: o_seg = SEG_6;
         4'd7: o_seg = SEG_7;
         4'd8: o_seg = SEG_8;
         4'd9: o_seg = SEG_9;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/laundry_vend_ctrl.sv
// Coin acceptor and vend controller: credit in nickels,
// priced options, nickel change, BCD/7-seg credit display.
module laundry_vend_ctrl
   import laundry_vend_ctrl_pkg::*;
#(
   parameter int NUM_PROD = DEF_NUM_PROD,
   parameter logic [16*NUM_PROD-1:0] PRICES = DEF_PRICES,
   parameter int MAX_CREDIT = 100
) (
   input  logic clock,
   input  logic reset,
   laundry_vend_ctrl_if.slave bus
);

   localparam int MAX_N = MAX_CREDIT / 5;
   localparam int CW    = $clog2(MAX_N + 1);

   state_t              r_state;
   logic [CW-1:0]       r_credit;
   logic [CW-1:0]       r_rem;
   logic [NUM_PROD-1:0] r_vend;
   logic                r_deny;
   logic                r_reject;
   logic                r_chg;

   logic                w_sel_any;
   logic [NUM_PROD-1:0] w_sel_oh;
   logic [15:0]         w_price;
   logic [15:0]         w_cred16;
   logic                w_afford;
   logic [CW-1:0]       w_left;
   logic [2:0]          w_coins;
   logic                w_coin_any;
   logic                w_coin_one;
   logic [7:0]          w_coin_val;
   logic [15:0]         w_sum;
   logic                w_coin_ok;
   logic [NUM_PROD-1:0] w_led;
   logic                w_busy;
   logic [CW-1:0]       w_disp;
   logic [9:0]          w_cents;
   logic [9:0]          w_tens;
   logic [3:0]          w_h;
   logic [3:0]          w_t;
   logic [3:0]          w_o;

   assign w_sel_any = |bus.i_sel;
   assign w_cred16  = 16'(r_credit);
   assign w_afford  = w_cred16 >= w_price;
   assign w_left    = CW'(w_cred16 - w_price);

   // Lowest-index select wins; its price in nickels
   always_comb begin
      w_sel_oh = '0;
      w_price  = '0;
      for (int i = NUM_PROD - 1; i >= 0; i--) begin
         if (bus.i_sel[i]) begin
            w_sel_oh    = '0;
            w_sel_oh[i] = 1'b1;
            w_price     = PRICES[16*i +: 16] / 16'd5;
         end
      end
   end

   assign w_coins    = {bus.i_quarter, bus.i_dime,
                        bus.i_nickel};
   assign w_coin_any = |w_coins;
   assign w_coin_one = $onehot(w_coins);

   // Value of a lone coin; mixed coins carry no value
   always_comb begin
      w_coin_val = 8'd0;
      if (w_coin_one) begin
         unique case (1'b1)
            w_coins[0]: w_coin_val = NICKEL_N;
            w_coins[1]: w_coin_val = DIME_N;
            w_coins[2]: w_coin_val = QUARTER_N;
            default:    w_coin_val = 8'd0;
         endcase
      end
   end

   assign w_sum     = w_cred16 + 16'(w_coin_val);
   assign w_coin_ok = w_coin_one && (w_sum <= 16'(MAX_N));

   // Affordability lamps follow the live credit register
   always_comb begin
      w_led = '0;
      for (int i = 0; i < NUM_PROD; i++) begin
         w_led[i] = w_cred16 >= (PRICES[16*i +: 16] / 16'd5);
      end
   end

   // Vend FSM with registered pulse outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_credit <= '0;
         r_rem    <= '0;
         r_vend   <= '0;
         r_deny   <= 1'b0;
         r_reject <= 1'b0;
         r_chg    <= 1'b0;
      end else begin
         r_vend   <= '0;
         r_deny   <= 1'b0;
         r_reject <= 1'b0;
         r_chg    <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_CREDIT: begin
               if (w_sel_any) begin
                  r_reject <= w_coin_any;
                  if (w_afford) begin
                     r_state  <= ST_VEND;
                     r_rem    <= w_left;
                     r_credit <= '0;
                     r_vend   <= w_sel_oh;
                  end else begin
                     r_deny <= 1'b1;
                  end
               end else if (bus.i_cancel &&
                            r_state == ST_CREDIT) begin
                  r_reject <= w_coin_any;
                  r_state  <= ST_CHANGE;
                  r_rem    <= r_credit;
                  r_credit <= '0;
                  r_chg    <= 1'b1;
               end else if (w_coin_any) begin
                  if (w_coin_ok) begin
                     r_credit <= w_sum[CW-1:0];
                     r_state  <= ST_CREDIT;
                  end else begin
                     r_reject <= 1'b1;
                  end
               end
            end
            ST_VEND: begin
               r_reject <= w_coin_any;
               r_deny   <= w_sel_any | bus.i_cancel;
               if (r_rem != '0) begin
                  r_state <= ST_CHANGE;
                  r_chg   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CHANGE: begin
               r_reject <= w_coin_any;
               r_deny   <= w_sel_any | bus.i_cancel;
               if (r_rem <= CW'(1)) begin
                  r_rem   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_rem <= r_rem - CW'(1);
                  r_chg <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_busy = (r_state == ST_VEND) ||
                   (r_state == ST_CHANGE);
   assign w_disp  = w_busy ? r_rem : r_credit;
   assign w_cents = 10'(w_disp) * 10'd5;
   assign w_tens  = w_cents / 10'd10;
   assign w_h     = 4'(w_cents / 10'd100);
   assign w_t     = 4'(w_tens % 10'd10);
   assign w_o     = 4'(w_cents % 10'd10);

   seg7_decode u_seg_h (.i_bcd(w_h), .o_seg(bus.o_seg_h));
   seg7_decode u_seg_t (.i_bcd(w_t), .o_seg(bus.o_seg_t));
   seg7_decode u_seg_o (.i_bcd(w_o), .o_seg(bus.o_seg_o));

   assign bus.o_vend          = r_vend;
   assign bus.o_deny          = r_deny;
   assign bus.o_coin_reject   = r_reject;
   assign bus.o_change_nickel = r_chg;
   assign bus.o_busy          = w_busy;
   assign bus.o_bcd_h         = w_h;
   assign bus.o_bcd_t         = w_t;
   assign bus.o_bcd_o         = w_o;
   assign bus.o_credit_led    = w_led;

endmodule

// File: tb/tb_laundry_vend_ctrl.sv
// Bench for laundry_vend_ctrl: directed panel scenarios then
// random traffic, checked against a cents-level model.
module tb_laundry_vend_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;

   laundry_vend_ctrl_if #(.NUM_PROD(3)) bus ();

   laundry_vend_ctrl #(
      .NUM_PROD(3),
      .PRICES({16'd80, 16'd50, 16'd20}),
      .MAX_CREDIT(100)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   int price [3] = '{20, 50, 80};
   logic [6:0] seg_tab [10] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

   // Model: cents; mode 0 idle/credit, 1 vend, 2 change
   int m_credit = 0;
   int m_rem    = 0;
   int m_mode   = 0;
   int e_vend   = 0;
   int e_deny   = 0;
   int e_rej    = 0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int disp;
      int led;
      disp = (m_mode != 0) ? m_rem : m_credit;
      led  = 0;
      for (int i = 0; i < 3; i++)
         if (m_credit >= price[i]) led |= (1 << i);
      check("vend",   32'(bus.o_vend), e_vend);
      check("deny",   32'(bus.o_deny), e_deny);
      check("reject", 32'(bus.o_coin_reject), e_rej);
      check("change", 32'(bus.o_change_nickel),
            32'(m_mode == 2));
      check("busy",   32'(bus.o_busy), 32'(m_mode != 0));
      check("bcd_h",  32'(bus.o_bcd_h), disp / 100);
      check("bcd_t",  32'(bus.o_bcd_t), (disp / 10) % 10);
      check("bcd_o",  32'(bus.o_bcd_o), disp % 10);
      check("seg_h",  32'(bus.o_seg_h),
            32'(seg_tab[disp / 100]));
      check("seg_t",  32'(bus.o_seg_t),
            32'(seg_tab[(disp / 10) % 10]));
      check("seg_o",  32'(bus.o_seg_o),
            32'(seg_tab[disp % 10]));
      check("led",    32'(bus.o_credit_led), led);
   endtask

   task automatic model_step(input int n, input int d,
                             input int q, input int s,
                             input int c);
      int ncoin;
      int val;
      int pick;
      ncoin  = n + d + q;
      val    = 5 * n + 10 * d + 25 * q;
      e_vend = 0;
      e_deny = 0;
      e_rej  = 0;
      if (m_mode == 0) begin
         pick = -1;
         for (int i = 2; i >= 0; i--)
            if ((s >> i) & 1) pick = i;
         if (pick >= 0) begin
            if (ncoin > 0) e_rej = 1;
            if (m_credit >= price[pick]) begin
               e_vend   = 1 << pick;
               m_rem    = m_credit - price[pick];
               m_credit = 0;
               m_mode   = 1;
            end else begin
               e_deny = 1;
            end
         end else if (c != 0 && m_credit > 0) begin
            if (ncoin > 0) e_rej = 1;
            m_rem    = m_credit;
            m_credit = 0;
            m_mode   = 2;
         end else if (ncoin > 0) begin
            if (ncoin == 1 && m_credit + val <= 100)
               m_credit += val;
            else
               e_rej = 1;
         end
      end else begin
         if (ncoin > 0) e_rej = 1;
         if (s != 0 || c != 0) e_deny = 1;
         if (m_mode == 1) begin
            m_mode = (m_rem > 0) ? 2 : 0;
         end else begin
            m_rem -= 5;
            if (m_rem == 0) m_mode = 0;
         end
      end
   endtask

   task automatic step(input int n, input int d,
                       input int q, input int s,
                       input int c);
      @(negedge clock);
      bus.i_nickel  = n[0];
      bus.i_dime    = d[0];
      bus.i_quarter = q[0];
      bus.i_sel     = s[2:0];
      bus.i_cancel  = c[0];
      model_step(n, d, q, s, c);
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic clear_inputs();
      bus.i_nickel  = 1'b0;
      bus.i_dime    = 1'b0;
      bus.i_quarter = 1'b0;
      bus.i_sel     = '0;
      bus.i_cancel  = 1'b0;
   endtask

   // Async reset a little after an edge; outputs clear at once
   task automatic do_reset();
      #2;
      reset = 1'b1;
      clear_inputs();
      m_credit = 0;
      m_rem    = 0;
      m_mode   = 0;
      e_vend   = 0;
      e_deny   = 0;
      e_rej    = 0;
      #1;
      check_all();
      @(negedge clock);
      reset = 1'b0;
      model_step(0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      check_all();
   endtask

   initial begin
      int r;
      int n;
      int d;
      int q;
      int s;
      int c;
      clear_inputs();
      #2;
      check_all();
      @(negedge clock);
      reset = 1'b0;

      // 25 + 5 = 30
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      check("bcd30_t", 32'(bus.o_bcd_t), 3);
      check("led30", 32'(bus.o_credit_led), 1);
      step(0, 0, 0, 0, 1);
      idle(8);

      // 45 denied for 50, then exact vend
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 2, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 2, 0);
      idle(3);

      // 100 ceiling, dime rejected, 16 nickels back
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(18);

      // Mixed coins rejected; all selects -> option 0
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 7, 0);
      idle(14);

      // Refund of 35 with coin and select during it
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 4, 0);
      idle(6);

      // 60: option 2 denied, option 1 vends, reset mid-change
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 4, 0);
      step(0, 0, 0, 2, 0);
      step(0, 0, 0, 0, 0);
      check("first_chg", 32'(bus.o_change_nickel), 1);
      do_reset();
      idle(4);

      // Random panel traffic
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if (r == 0) begin
            do_reset();
         end else begin
            n = ($urandom_range(0, 99) < 20) ? 1 : 0;
            d = ($urandom_range(0, 99) < 15) ? 1 : 0;
            q = ($urandom_range(0, 99) < 20) ? 1 : 0;
            s = ($urandom_range(0, 99) < 12)
                ? $urandom_range(1, 7) : 0;
            c = ($urandom_range(0, 99) < 4) ? 1 : 0;
            step(n, d, q, s, c);
         end
      end
      idle(25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
